// File: rtl/dp_test_sequencer.sv
// Double-pulse test sequencer: qualifies bus voltage, then drives one lead/P1/gap/P2/trail pattern on
// the selected gate pair. Optional over-voltage abort to a latched FAULT is enabled by DP_OV_ABORT_EN.
module dp_test_sequencer #(
    parameter logic [15:0] V_LO       = 16'h08B0,
    parameter logic [15:0] V_HI       = 16'h0C0C,
    parameter int          STABLE_CNT = 16,
    parameter logic [15:0] QUAL_TMO   = 16'd40000,
    parameter int          DEAD_CYC   = 50,
    parameter int          T1_CYC     = 500,
    parameter int          GAP_CYC    = 250,
    parameter int          T2_CYC     = 250,
    parameter int          COOL_CYC   = 8000
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        clear,
    input  logic [15:0] volt,
    input  logic        volt_valid,
    output logic        ka_1,
    output logic        ka_2,
    output logic        kb_1,
    output logic        kb_2,
    output logic        busy,
    output logic        done,
    output logic        reject,
    output logic        fault,
    output logic        active_ch
);

    typedef enum logic [3:0] {
        S_IDLE, S_QUAL, S_LEAD, S_P1, S_GAP, S_P2, S_TRAIL, S_COOL, S_FAULT
    } state_t;

    localparam int          STAB_W    = $clog2(STABLE_CNT + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
    localparam logic [15:0] QUAL_LD   = QUAL_TMO - 16'd1;
    localparam logic [15:0] DEAD_LD   = 16'(DEAD_CYC - 1);
    localparam logic [15:0] T1_LD     = 16'(T1_CYC - 1);
    localparam logic [15:0] GAP_LD    = 16'(GAP_CYC - 1);
    localparam logic [15:0] T2_LD     = 16'(T2_CYC - 1);
    localparam logic [15:0] COOL_LD   = 16'(COOL_CYC - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              active_ch_q, active_ch_d;
    logic              done_q, done_d;
    logic              reject_q, reject_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;
    logic              ka_1_q, ka_1_d, ka_2_q, ka_2_d;
    logic              kb_1_q, kb_1_d, kb_2_q, kb_2_d;

    logic              in_win_s;
    logic              cnt_done_s;
    logic              ov_abort_s;
    logic              win_d_s;
    logic              pulse_d_s;

    assign in_win_s   = (volt > V_LO) && (volt <= V_HI);
    assign cnt_done_s = (cnt_q == 16'd0);

`ifdef DP_OV_ABORT_EN
    assign ov_abort_s = volt_valid && (volt > V_HI);
`else
    assign ov_abort_s = 1'b0;
`endif

    // Next-state, duration counter, stability count and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_done_s ? 16'd0 : (cnt_q - 16'd1);
        stab_d      = stab_q;
        active_ch_d = active_ch_q;
        done_d      = 1'b0;
        reject_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_QUAL;
                    cnt_d   = QUAL_LD;
                    stab_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_QUAL: begin
                // Qualifying on the final sample takes priority over a simultaneous timeout.
                if (volt_valid && in_win_s && (stab_q == STAB_LAST)) begin
                    state_d = S_LEAD;
                    cnt_d   = DEAD_LD;
                end else if (cnt_done_s) begin
                    state_d  = S_IDLE;
                    reject_d = 1'b1;
                end else if (volt_valid) begin
                    stab_d = in_win_s ? (stab_q + STAB_W'(1)) : '0;
                end else begin
                    stab_d = stab_q;
                end
            end
            S_LEAD: begin
                if (ov_abort_s)      state_d = S_FAULT;
                else if (cnt_done_s) begin state_d = S_P1; cnt_d = T1_LD; end
                else                 state_d = S_LEAD;
            end
            S_P1: begin
                if (ov_abort_s)      state_d = S_FAULT;
                else if (cnt_done_s) begin state_d = S_GAP; cnt_d = GAP_LD; end
                else                 state_d = S_P1;
            end
            S_GAP: begin
                if (ov_abort_s)      state_d = S_FAULT;
                else if (cnt_done_s) begin state_d = S_P2; cnt_d = T2_LD; end
                else                 state_d = S_GAP;
            end
            S_P2: begin
                if (ov_abort_s)      state_d = S_FAULT;
                else if (cnt_done_s) begin state_d = S_TRAIL; cnt_d = DEAD_LD; end
                else                 state_d = S_P2;
            end
            S_TRAIL: begin
                if (ov_abort_s)      state_d = S_FAULT;
                else if (cnt_done_s) begin state_d = S_COOL; cnt_d = COOL_LD; end
                else                 state_d = S_TRAIL;
            end
            S_COOL: begin
                if (cnt_done_s) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    active_ch_d = ~active_ch_q;
                end else begin
                    state_d = S_COOL;
                end
            end
            S_FAULT: begin
                if (clear) state_d = S_IDLE;
                else       state_d = S_FAULT;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the next state so they line up with the state register.
        win_d_s   = state_d inside {S_LEAD, S_P1, S_GAP, S_P2, S_TRAIL};
        pulse_d_s = state_d inside {S_P1, S_P2};
        ka_2_d    = win_d_s   && !active_ch_q;
        ka_1_d    = pulse_d_s && !active_ch_q;
        kb_2_d    = win_d_s   &&  active_ch_q;
        kb_1_d    = pulse_d_s &&  active_ch_q;
        busy_d    = (state_d != S_IDLE) && (state_d != S_FAULT);
        fault_d   = (state_d == S_FAULT);
    end

    // State and output registers; asynchronous reset drops the gates immediately.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            stab_q      <= '0;
            active_ch_q <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
            ka_1_q      <= 1'b0;
            ka_2_q      <= 1'b0;
            kb_1_q      <= 1'b0;
            kb_2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            active_ch_q <= active_ch_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
            ka_1_q      <= ka_1_d;
            ka_2_q      <= ka_2_d;
            kb_1_q      <= kb_1_d;
            kb_2_q      <= kb_2_d;
        end
    end

    assign ka_1      = ka_1_q;
    assign ka_2      = ka_2_q;
    assign kb_1      = kb_1_q;
    assign kb_2      = kb_2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign reject    = reject_q;
    assign fault     = fault_q;
    assign active_ch = active_ch_q;

endmodule

// File: tb/tb_dp_test_sequencer.sv
// Directed bench for dp_test_sequencer: timing of both pairs, reject, stability reset, OV handling, async reset.
`timescale 1ns/1ps
module tb_dp_test_sequencer;

    logic        clk = 1'b0;
    logic        sys_rst, start, clear;
    logic [15:0] volt;
    logic        volt_valid;
    logic        ka_1, ka_2, kb_1, kb_2, busy, done, reject, fault, active_ch;

    int          total = 0;
    int          bad   = 0;
    bit          vv_en = 1'b0;
    logic [15:0] volt_hold = 16'h0A00;
    logic [15:0] vq[$];
    int          phase = 0;
    bit          exp_ch = 1'b0;

    dp_test_sequencer dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .clear(clear),
        .volt(volt), .volt_valid(volt_valid),
        .ka_1(ka_1), .ka_2(ka_2), .kb_1(kb_1), .kb_2(kb_2),
        .busy(busy), .done(done), .reject(reject), .fault(fault), .active_ch(active_ch)
    );

    initial forever #12.5 clk = ~clk;

    // ADC model: one volt_valid strobe every 8 cycles, taking queued samples first.
    initial begin
        volt = 16'h0000;
        volt_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            volt_valid = 1'b0;
            if (vv_en) begin
                phase = phase + 1;
                if (phase >= 8) begin
                    phase = 0;
                    volt_valid = 1'b1;
                    if (vq.size() > 0) volt = vq.pop_front();
                    else volt = volt_hold;
                end
            end else begin
                phase = 0;
            end
        end
    end

    initial begin
        #2400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Measures one run on pair ch from the current negedge; returns error counts and cooldown length.
    task automatic capture_run(input bit ch, output int e1, output int e2, output int eo,
                               output int cool, output bit to);
        logic k1, k2;
        logic [1:0] oth;
        int n;
        e1 = 0; e2 = 0; eo = 0; cool = 0; to = 1'b0; n = 0;
        while (((ch ? kb_2 : ka_2) !== 1'b1) && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) begin to = 1'b1; return; end
        for (int i = 0; i < 1100; i++) begin
            k1  = ch ? kb_1 : ka_1;
            k2  = ch ? kb_2 : ka_2;
            oth = ch ? {ka_1, ka_2} : {kb_1, kb_2};
            if (k1 !== (((i >= 50) && (i < 550)) || ((i >= 800) && (i < 1050)))) e1++;
            if (k2 !== 1'b1) e2++;
            if (oth !== 2'b00) eo++;
            @(negedge clk);
        end
        while (done !== 1'b1 && cool < 9000) begin
            if ({ka_1, ka_2, kb_1, kb_2} !== 4'b0000) eo++;
            @(negedge clk); cool++;
        end
        if (cool >= 9000) to = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; start = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ka_1, ka_2, kb_1, kb_2, busy, done, reject, fault, active_ch} !== 9'b0) begin
            bad++; $display("FAIL reset_hold: got %b want 000000000",
                            {ka_1, ka_2, kb_1, kb_2, busy, done, reject, fault, active_ch});
        end
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ka_1, ka_2, kb_1, kb_2, busy, done, reject, fault, active_ch} !== 9'b0) begin
            bad++; $display("FAIL reset_release: got %b want 000000000",
                            {ka_1, ka_2, kb_1, kb_2, busy, done, reject, fault, active_ch});
        end
    endtask

    task automatic test_pair_run(input string tag);
        int e1, e2, eo, cool;
        bit to;
        volt_hold = 16'h0A00; vv_en = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (active_ch !== exp_ch) begin
            bad++; $display("FAIL %s_ch_before: got %b want %b", tag, active_ch, exp_ch);
        end
        pulse_start();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_qual: got %b want 1", tag, busy); end
        capture_run(exp_ch, e1, e2, eo, cool, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout: got %b want 0", tag, to); end
        total++;
        if (e1 != 0) begin bad++; $display("FAIL %s_k1_shape: got %0d bad cycles want 0", tag, e1); end
        total++;
        if (e2 != 0) begin bad++; $display("FAIL %s_k2_window: got %0d bad cycles want 0", tag, e2); end
        total++;
        if (eo != 0) begin bad++; $display("FAIL %s_stray_gates: got %0d bad cycles want 0", tag, eo); end
        total++;
        if (cool != 8000) begin bad++; $display("FAIL %s_cool_len: got %0d want 8000", tag, cool); end
        exp_ch = ~exp_ch;
        total++;
        if (active_ch !== exp_ch) begin
            bad++; $display("FAIL %s_ch_after: got %b want %b", tag, active_ch, exp_ch);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_done: got %b want 0", tag, busy); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL %s_done_width: got %b want 0", tag, done); end
    endtask

    task automatic test_low_voltage();
        int k, g;
        volt_hold = 16'h0800;
        repeat (10) @(negedge clk);
        pulse_start();
        k = 0; g = 0;
        while (reject !== 1'b1 && k < 41000) begin
            if ({ka_1, ka_2, kb_1, kb_2} !== 4'b0000) g++;
            @(negedge clk); k++;
        end
        total++;
        if (k != 40000) begin bad++; $display("FAIL reject_time: got %0d want 40000", k); end
        total++;
        if (g != 0) begin bad++; $display("FAIL reject_gates: got %0d active cycles want 0", g); end
        total++;
        if (active_ch !== exp_ch) begin
            bad++; $display("FAIL reject_ch: got %b want %b", active_ch, exp_ch);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reject_busy: got %b want 0", busy); end
        @(negedge clk);
        total++;
        if (reject !== 1'b0) begin bad++; $display("FAIL reject_width: got %b want 0", reject); end
        volt_hold = 16'h0A00;
    endtask

    task automatic test_ov_gap();
        int n, fcnt;
        volt_hold = 16'h0A00;
        repeat (10) @(negedge clk);
        pulse_start();
        n = 0;
        while (((exp_ch ? kb_2 : ka_2) !== 1'b1) && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (n >= 2000) begin bad++; $display("FAIL ov_lead: got no lead want lead"); end
        repeat (560) @(negedge clk);
        volt_hold = 16'h0C10;
`ifdef DP_OV_ABORT_EN
        n = 0;
        while (((exp_ch ? kb_2 : ka_2) === 1'b1) && n < 40) begin @(negedge clk); n++; end
        volt_hold = 16'h0A00;
        total++;
        if ({ka_1, ka_2, kb_1, kb_2, fault, busy, done} !== 7'b0000100) begin
            bad++; $display("FAIL ov_abort: got %b want 0000100", {ka_1, ka_2, kb_1, kb_2, fault, busy, done});
        end
        pulse_start();
        total++;
        if ({fault, busy} !== 2'b10) begin
            bad++; $display("FAIL ov_start_ignored: got %b want 10", {fault, busy});
        end
        @(negedge clk); start = 1'b1; clear = 1'b1;
        @(negedge clk); start = 1'b0; clear = 1'b0;
        total++;
        if ({fault, busy} !== 2'b00) begin
            bad++; $display("FAIL ov_clear: got %b want 00", {fault, busy});
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ov_clear_start_drop: got %b want 0", busy); end
        total++;
        if (active_ch !== exp_ch) begin
            bad++; $display("FAIL ov_ch: got %b want %b", active_ch, exp_ch);
        end
`else
        repeat (20) @(negedge clk);
        volt_hold = 16'h0A00;
        n = 0; fcnt = 0;
        while (done !== 1'b1 && n < 10000) begin
            if (fault !== 1'b0) fcnt++;
            @(negedge clk); n++;
        end
        total++;
        if (n != 8520) begin bad++; $display("FAIL ov_ignored_done: got %0d want 8520", n); end
        total++;
        if (fcnt != 0) begin bad++; $display("FAIL ov_no_fault: got %0d want 0", fcnt); end
        exp_ch = ~exp_ch;
        total++;
        if (active_ch !== exp_ch) begin
            bad++; $display("FAIL ov_ch: got %b want %b", active_ch, exp_ch);
        end
`endif
    endtask

    task automatic test_stability();
        int cnt, n;
        vv_en = 1'b0;
        @(negedge clk);
        vq.push_back(16'h0A00); vq.push_back(16'h0C0C); vq.push_back(16'h08B1);
        vq.push_back(16'h08B0);
        for (int i = 0; i < 15; i++)
            vq.push_back((i % 3 == 0) ? 16'h0C0C : ((i % 3 == 1) ? 16'h08B1 : 16'h0A00));
        vq.push_back(16'h0C0D);
        for (int i = 0; i < 16; i++)
            vq.push_back((i % 3 == 0) ? 16'h08B1 : ((i % 3 == 1) ? 16'h0C0C : 16'h0A00));
        pulse_start();
        vv_en = 1'b1;
        cnt = 0; n = 0;
        while (((exp_ch ? kb_2 : ka_2) !== 1'b1) && n < 1000) begin
            if (volt_valid === 1'b1) cnt++;
            @(negedge clk); n++;
        end
        total++;
        if (cnt != 36) begin bad++; $display("FAIL stab_samples: got %0d want 36", cnt); end
        total++;
        if ((exp_ch ? {ka_1, ka_2} : {kb_1, kb_2}) !== 2'b00) begin
            bad++; $display("FAIL stab_other_pair: got %b want 00", exp_ch ? {ka_1, ka_2} : {kb_1, kb_2});
        end
    endtask

    task automatic test_reset_mid_p1();
        repeat (150) @(negedge clk);
        total++;
        if ((exp_ch ? kb_1 : ka_1) !== 1'b1) begin
            bad++; $display("FAIL p1_active: got %b want 1", exp_ch ? kb_1 : ka_1);
        end
        #3 sys_rst = 1'b1;
        #1;
        total++;
        if ({ka_1, ka_2, kb_1, kb_2, busy, active_ch} !== 6'b0) begin
            bad++; $display("FAIL async_drop: got %b want 000000", {ka_1, ka_2, kb_1, kb_2, busy, active_ch});
        end
        @(negedge clk); sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_ch = 1'b0;
        total++;
        if ({ka_1, ka_2, kb_1, kb_2, busy, fault, active_ch} !== 7'b0) begin
            bad++; $display("FAIL post_reset_idle: got %b want 0000000",
                            {ka_1, ka_2, kb_1, kb_2, busy, fault, active_ch});
        end
    endtask

    initial begin
        sys_rst = 1'b1; start = 1'b0; clear = 1'b0;
        test_reset();
        test_pair_run("pair_a");
        test_pair_run("pair_b");
        test_low_voltage();
        test_ov_gap();
        test_stability();
        test_reset_mid_p1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
